// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs symbolic LUI/AUIPC/JAL/JALR/BRANCH fields into
// 32-bit words with a range-checked immediate and an auto-incrementing word address.
module instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [7:0]        err_count
);

  localparam logic [2:0] OP_LUI    = 3'd0;
  localparam logic [2:0] OP_AUIPC  = 3'd1;
  localparam logic [2:0] OP_JAL    = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ILLEGAL = 3'd1;
  localparam logic [2:0] E_FUNCT3  = 3'd2;
  localparam logic [2:0] E_ALIGN   = 3'd3;
  localparam logic [2:0] E_RANGE   = 3'd4;
  localparam logic [2:0] E_ULOW    = 3'd5;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (op)
      OP_LUI:    w = {imm[31:12], rd, 7'b0110111};
      OP_AUIPC:  w = {imm[31:12], rd, 7'b0010111};
      OP_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      OP_JALR:   w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      default:   w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              r_state;
  logic [31:0]         r_word_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic [ADDR_W-1:0]   r_next_addr;
  logic                r_err_p1;
  logic [2:0]          r_err_code;
  logic [7:0]          r_err_count;

  logic signed [31:0]  w_imm;
  logic [2:0]          w_code;
  logic [31:0]         w_word;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_base;

  assign w_imm    = in_imm;
  assign in_ready = (r_state == S_EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_word   = encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
  assign w_base   = start ? BASE_ADDR : r_next_addr;

  // Checks are ordered so the first failing one determines the reported code
  always_comb begin
    w_code = E_NONE;
    case (in_op)
      OP_LUI, OP_AUIPC: begin
        if (in_imm[11:0] != 12'd0) w_code = E_ULOW;
      end
      OP_JAL: begin
        if (in_imm[0]) w_code = E_ALIGN;
        else if (w_imm < -32'sd1048576 || w_imm > 32'sd1048574) w_code = E_RANGE;
      end
      OP_JALR: begin
        if (w_imm < -32'sd2048 || w_imm > 32'sd2047) w_code = E_RANGE;
      end
      OP_BRANCH: begin
        if (in_funct3 == 3'd2 || in_funct3 == 3'd3) w_code = E_FUNCT3;
        else if (in_imm[0]) w_code = E_ALIGN;
        else if (w_imm < -32'sd4096 || w_imm > 32'sd4094) w_code = E_RANGE;
      end
      default: w_code = E_ILLEGAL;
    endcase
  end

  // Stage p1: output register, address counter and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_word_p1   <= 32'd0;
      r_addr_p1   <= '0;
      r_next_addr <= BASE_ADDR;
      r_err_p1    <= 1'b0;
      r_err_code  <= E_NONE;
      r_err_count <= 8'd0;
    end else begin
      r_err_p1 <= 1'b0;
      if (w_accept && w_code == E_NONE) begin
        r_state     <= S_FULL;
        r_word_p1   <= w_word;
        r_addr_p1   <= w_base;
        r_next_addr <= w_base + ADDR_W'(1);
      end else begin
        if (r_state == S_FULL && out_ready) r_state <= S_EMPTY;
        if (start) r_next_addr <= BASE_ADDR;
        if (w_accept) begin
          r_err_p1    <= 1'b1;
          r_err_code  <= w_code;
          r_err_count <= sat_inc8(r_err_count);
        end
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_word  = r_word_p1;
  assign out_addr  = r_addr_p1;
  assign err       = r_err_p1;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default instance plus a 2-bit address instance for wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [2:0]  in_op, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready0, out_valid0, err0;
  logic [31:0] out_word0;
  logic [9:0]  out_addr0;
  logic [2:0]  err_code0;
  logic [7:0]  err_count0;

  logic        in_ready1, out_valid1, err1;
  logic [31:0] out_word1;
  logic [1:0]  out_addr1;
  logic [2:0]  err_code1;
  logic [7:0]  err_count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid0),
    .out_ready(out_ready), .out_word(out_word0), .out_addr(out_addr0),
    .err(err0), .err_code(err_code0), .err_count(err_count0)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid1),
    .out_ready(out_ready), .out_word(out_word1), .out_addr(out_addr1),
    .err(err1), .err_code(err_code1), .err_count(err_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] word, input logic [9:0] addr);
    chk({tag, "_valid"}, {31'd0, out_valid0}, 32'd1);
    chk({tag, "_word"}, out_word0, word);
    chk({tag, "_addr"}, {22'd0, out_addr0}, {22'd0, addr});
  endtask

  task automatic chk_err(input string tag, input logic [2:0] code, input logic [7:0] cnt);
    chk({tag, "_err"}, {31'd0, err0}, 32'd1);
    chk({tag, "_code"}, {29'd0, err_code0}, {29'd0, code});
    chk({tag, "_count"}, {24'd0, err_count0}, {24'd0, cnt});
    chk({tag, "_novalid"}, {31'd0, out_valid0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'd0;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_word", out_word0, 32'd0);
    chk("rst_addr", {22'd0, out_addr0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_code", {29'd0, err_code0}, 32'd0);
    chk("rst_count", {24'd0, err_count0}, 32'd0);
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready0}, 32'd1);

    drive(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    tick();
    chk_out("lui", 32'h123452B7, 10'd0);

    start = 1'b1;
    drive(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
    tick();
    start = 1'b0;
    chk_out("jal_start", 32'h008000EF, 10'd0);
    drive(3'd3, 5'd0, 5'd1, 5'd0, 3'd5, 32'd0);
    tick();
    chk_out("jalr", 32'h00008067, 10'd1);
    idle();
    tick();
    chk("drain_valid", {31'd0, out_valid0}, 32'd0);

    drive(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
    tick();
    chk_out("br_m4", 32'hFE208EE3, 10'd2);
    drive(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4094);
    tick();
    chk_out("br_4094", 32'h7E208FE3, 10'd3);
    idle();
    tick();

    drive(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096);
    tick();
    chk_err("br_4096", 3'd4, 8'd1);
    idle();
    tick();
    chk("err_pulse_end", {31'd0, err0}, 32'd0);
    chk("err_code_held", {29'd0, err_code0}, 32'd4);

    drive(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    tick();
    chk_err("jal_odd", 3'd3, 8'd2);
    drive(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    tick();
    chk_err("op6", 3'd1, 8'd3);
    drive(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00001001);
    tick();
    chk_err("lui_low", 3'd5, 8'd4);
    drive(3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 32'd1);
    tick();
    chk_err("br_f3", 3'd2, 8'd5);
    drive(3'd3, 5'd0, 5'd1, 5'd0, 3'd0, 32'd2048);
    tick();
    chk_err("jalr_2048", 3'd4, 8'd6);

    drive(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 32'hFFFFF000);
    tick();
    chk_out("auipc_after_err", 32'hFFFFF197, 10'd4);

    drive(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    for (int i = 0; i < 256; i++) tick();
    chk("sat_err", {31'd0, err0}, 32'd1);
    chk("sat_count", {24'd0, err_count0}, 32'd255);
    tick();
    chk("sat_count_hold", {24'd0, err_count0}, 32'd255);
    chk("sat_code", {29'd0, err_code0}, 32'd1);

    do_reset();
    chk("rst2_count", {24'd0, err_count0}, 32'd0);
    out_ready = 1'b0;
    drive(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    tick();
    chk_out("bp_first", 32'h123452B7, 10'd0);
    drive(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
    #1;
    chk("bp_ready_low", {31'd0, in_ready0}, 32'd0);
    tick();
    chk_out("bp_hold1", 32'h123452B7, 10'd0);
    tick();
    chk_out("bp_hold2", 32'h123452B7, 10'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_high", {31'd0, in_ready0}, 32'd1);
    tick();
    chk_out("bp_second", 32'h008000EF, 10'd1);
    idle();
    tick();
    chk("bp_drain", {31'd0, out_valid0}, 32'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 32'd0);
      tick();
      chk($sformatf("wrap_addr%0d", i), {30'd0, out_addr1}, 32'(i % 4));
      chk($sformatf("wrap_word%0d", i), out_word1, 32'h37 | (32'(i) << 7));
      chk($sformatf("nowrap_addr%0d", i), {22'd0, out_addr0}, 32'(i));
    end
    idle();

    out_ready = 1'b0;
    tick();
    tick();
    chk("mid_full", {31'd0, out_valid0}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("mid_rst_word", out_word0, 32'd0);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, in_ready0}, 32'd1);

    drive(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 32'hFFFFF000);
    tick();
    chk_out("st_first", 32'hFFFFF197, 10'd0);
    idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("st_undisturbed", 32'hFFFFF197, 10'd0);
    out_ready = 1'b1;
    drive(3'd3, 5'd0, 5'd1, 5'd0, 3'd0, 32'd0);
    tick();
    chk_out("st_rebased", 32'h00008067, 10'd0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
